ftdi_async_fifo: RTL
====================

Name: ftdi_async_fifo

Overview:
Next-generation FTDI 245-style asynchronous FIFO bridge: byte streams on the core side, FT245 async pins on the device side. Adds internal RX/TX buffering of parametrised depth, programmable strobe/setup/recovery timing in clk_i cycles, fair round-robin RX/TX arbitration, and automatic SIWU flush after TX inactivity. Sits between the FTDI pad ring and the bridge protocol layer.

Parameters:
RX_DEPTH, 16, RX buffer entries (power of 2, >=2)
TX_DEPTH, 16, TX buffer entries (power of 2, >=2)
RD_STROBE, 2, cycles RD# held low before sampling (>=1)
WR_SETUP, 1, cycles data/OE driven before WR# falls (>=1)
WR_STROBE, 2, cycles WR# held low (>=1)
RECOVER, 2, idle cycles after each transfer (>=2, covers flag resync)
SIWU_TIMEOUT, 0, idle cycles with empty TX buffer before SIWU pulse; 0 disables

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
ftdi_rxf_i  in  1  RXF#, async, low = device has data
ftdi_txe_i  in  1  TXE#, async, low = device has space
ftdi_data_in_i  in  8  pad read data
ftdi_siwua_o  out  1  SIWU#, active low
ftdi_wrn_o  out  1  WR#
ftdi_rdn_o  out  1  RD#
ftdi_oen_o  out  1  pad output enable, active low
ftdi_data_out_o  out  8  pad write data
inport_valid_i  in  1  TX byte valid
inport_data_i  in  8  TX byte
inport_accept_o  out  1  TX buffer not full
outport_valid_o  out  1  RX buffer not empty
outport_data_o  out  8  RX buffer head (show-ahead)
outport_accept_i  in  1  consumer pops RX head
rx_level_o  out  clog2(RX_DEPTH)+1  RX occupancy
tx_level_o  out  clog2(TX_DEPTH)+1  TX occupancy

Behaviour:
- Reset: rst_i, asynchronous, active-high; clock clk_i. rdn/wrn/oen/siwua=1, data_out=0, both buffers empty, levels 0, state IDLE, last_dir=TX (RX wins first tie). Reset mid-transfer: strobes deassert immediately, buffered data discarded.
- rxf/txe pass 2-flop synchronisers reset to 1; FSM uses only synchronised copies.
- Core side: push TX on inport_valid_i & inport_accept_o; pop RX on outport_valid_o & outport_accept_i. Simultaneous push/pop on one buffer leaves level unchanged. Pop when empty / push when full never occurs (handshake-gated).
- rx_req = ~rxf_sync & rx_level<RX_DEPTH; tx_req = ~txe_sync & tx_level!=0.
- States: IDLE, RX_STROBE, TX_SETUP, TX_STROBE, RECOVER, SIWU. Per-state down-counter loaded on entry.
- IDLE: both reqs -> serve direction opposite last_dir; one req -> serve it. Update last_dir on grant. Every grant costs one IDLE cycle.
- RX_STROBE: rdn registered low on entry edge, held RD_STROBE cycles; on final edge ftdi_data_in_i pushed into RX buffer, rdn->1, -> RECOVER.
- TX_SETUP: on entry edge oen->0, data_out<=TX head; WR_SETUP cycles -> TX_STROBE (wrn->0). WR_STROBE cycles; final edge wrn->1, TX pop, -> RECOVER with oen/data held.
- RECOVER: RECOVER cycles, oen->1 on exit, -> IDLE.
- SIWU (SIWU_TIMEOUT>0): dirty flag set on each TX pop. Idle counter increments in IDLE while dirty & TX empty & no grant; cleared otherwise. At SIWU_TIMEOUT -> SIWU: siwua low exactly 2 cycles, clear dirty, -> RECOVER. SIWU not interrupted by reqs.
- Elaboration error if any parameter violates its bound.

Test Plan:
- Single RX, defaults: ftdi_rxf_i falls, data 0xA5 -> rdn low edges 3..5 (2 cycles), outport_valid_o=1 with 0xA5 after edge 5, rx_level_o=1.
- Single TX, defaults: push 0x3C, txe low -> oen low 1 cycle before wrn; wrn low 2 cycles, data_out=0x3C stable oen-low..RECOVER end; tx_level_o 1->0.
- Both reqs held low, 4 TX bytes queued, RX stream -> grants alternate RX,TX,RX,TX; RX byte order preserved.
- RX backpressure: outport_accept_i=0, RX_DEPTH=4, rxf low -> exactly 4 reads, rdn stays high, rx_level_o=4; one pop restarts reads.
- SIWU_TIMEOUT=8: write 1 byte, stay idle -> siwua low 2 cycles 8 idle cycles after pop; no second pulse without new TX.
- Reset asserted mid-TX_STROBE -> wrn/oen high same cycle, levels 0, outport_valid_o=0.

Source files
------------

// File: rtl/ftdi_async_fifo_if.sv
// Core-side byte stream bundle: TX bytes in, RX bytes out (show-ahead).
interface ftdi_async_fifo_if;
  logic       inport_valid_i;
  logic [7:0] inport_data_i;
  logic       inport_accept_o;
  logic       outport_valid_o;
  logic [7:0] outport_data_o;
  logic       outport_accept_i;

  // slave: the bridge itself
  modport slave (
    input  inport_valid_i, inport_data_i, outport_accept_i,
    output inport_accept_o, outport_valid_o, outport_data_o
  );

  // master: the protocol layer driving TX and consuming RX
  modport master (
    output inport_valid_i, inport_data_i, outport_accept_i,
    input  inport_accept_o, outport_valid_o, outport_data_o
  );
endinterface

// File: rtl/ftdi_async_fifo.sv
// FT245-style async FIFO bridge: RX/TX byte buffers, programmable pad
// strobe timing, round-robin RX/TX arbitration and SIWU flush on TX idle.
module ftdi_async_fifo #(
  parameter int RX_DEPTH     = 16,
  parameter int TX_DEPTH     = 16,
  parameter int RD_STROBE    = 2,
  parameter int WR_SETUP     = 1,
  parameter int WR_STROBE    = 2,
  parameter int RECOVER      = 2,
  parameter int SIWU_TIMEOUT = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          ftdi_rxf_i,
  input  logic                          ftdi_txe_i,
  input  logic [7:0]                    ftdi_data_in_i,
  output logic                          ftdi_siwua_o,
  output logic                          ftdi_wrn_o,
  output logic                          ftdi_rdn_o,
  output logic                          ftdi_oen_o,
  output logic [7:0]                    ftdi_data_out_o,
  ftdi_async_fifo_if.slave              bus_if,
  output logic [$clog2(RX_DEPTH):0]     rx_level_o,
  output logic [$clog2(TX_DEPTH):0]     tx_level_o
);

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  localparam int RAW     = $clog2(RX_DEPTH);
  localparam int TAW     = $clog2(TX_DEPTH);
  localparam int CNT_MAX = max2(max2(max2(RD_STROBE, WR_SETUP), max2(WR_STROBE, RECOVER)), 2);
  localparam int CW      = $clog2(CNT_MAX);
  localparam int IW      = max2($clog2(SIWU_TIMEOUT + 1), 1);

  generate
    if (RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_rx_depth
      $error("RX_DEPTH must be a power of 2 and >= 2");
    end
    if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_bad_tx_depth
      $error("TX_DEPTH must be a power of 2 and >= 2");
    end
    if (RD_STROBE < 1 || WR_SETUP < 1 || WR_STROBE < 1) begin : g_bad_strobe
      $error("RD_STROBE, WR_SETUP and WR_STROBE must be >= 1");
    end
    if (RECOVER < 2) begin : g_bad_recover
      $error("RECOVER must be >= 2 to cover flag resynchronisation");
    end
    if (SIWU_TIMEOUT < 0) begin : g_bad_siwu
      $error("SIWU_TIMEOUT must be >= 0");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE, ST_RX_STROBE, ST_TX_SETUP, ST_TX_STROBE, ST_RECOVER, ST_SIWU
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;
  logic [IW-1:0]  r_idle, w_idle_nxt;
  logic           r_rxf_meta, r_rxf_sync, r_txe_meta, r_txe_sync;
  logic           r_rdn, r_wrn, r_oen, r_siwua, r_last_tx, r_dirty;
  logic           w_rdn_nxt, w_wrn_nxt, w_oen_nxt, w_siwua_nxt, w_last_tx_nxt, w_dirty_nxt;
  logic [7:0]     r_dout, w_dout_nxt;
  logic           w_rx_push, w_rx_pop, w_tx_push, w_tx_pop, w_rx_req, w_tx_req;

  logic [7:0]     r_rx_mem [RX_DEPTH];
  logic [7:0]     r_tx_mem [TX_DEPTH];
  logic [RAW-1:0] r_rx_wr, r_rx_rd;
  logic [TAW-1:0] r_tx_wr, r_tx_rd;
  logic [RAW:0]   r_rx_level;
  logic [TAW:0]   r_tx_level;

  // RXF#/TXE# are asynchronous to clk_i; idle-high through reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rxf_meta <= 1'b1; r_rxf_sync <= 1'b1;
      r_txe_meta <= 1'b1; r_txe_sync <= 1'b1;
    end else begin
      r_rxf_meta <= ftdi_rxf_i; r_rxf_sync <= r_rxf_meta;
      r_txe_meta <= ftdi_txe_i; r_txe_sync <= r_txe_meta;
    end
  end

  assign w_tx_push = bus_if.inport_valid_i & bus_if.inport_accept_o;
  assign w_rx_pop  = bus_if.outport_valid_o & bus_if.outport_accept_i;
  assign w_rx_req  = ~r_rxf_sync & (r_rx_level < (RAW+1)'(RX_DEPTH));
  assign w_tx_req  = ~r_txe_sync & (r_tx_level != '0);

  // buffer storage is not reset; pointers and levels define validity
  always_ff @(posedge clk_i) begin
    if (w_rx_push) r_rx_mem[r_rx_wr] <= ftdi_data_in_i;
    if (w_tx_push) r_tx_mem[r_tx_wr] <= bus_if.inport_data_i;
  end

  // buffer pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rx_wr <= '0; r_rx_rd <= '0; r_rx_level <= '0;
      r_tx_wr <= '0; r_tx_rd <= '0; r_tx_level <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + RAW'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + RAW'(1);
      if (w_tx_push) r_tx_wr <= r_tx_wr + TAW'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + TAW'(1);
      r_rx_level <= r_rx_level + (RAW+1)'(w_rx_push) - (RAW+1)'(w_rx_pop);
      r_tx_level <= r_tx_level + (TAW+1)'(w_tx_push) - (TAW+1)'(w_tx_pop);
    end
  end

  // pad FSM: arbitration, strobe timing, SIWU idle detection
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt - CW'(1);
    w_idle_nxt    = '0;
    w_rdn_nxt     = r_rdn;
    w_wrn_nxt     = r_wrn;
    w_oen_nxt     = r_oen;
    w_siwua_nxt   = r_siwua;
    w_dout_nxt    = r_dout;
    w_last_tx_nxt = r_last_tx;
    w_dirty_nxt   = r_dirty;
    w_rx_push     = 1'b0;
    w_tx_pop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = r_cnt;
        // on a tie RX wins unless it was the last direction served
        if (w_rx_req && (!w_tx_req || r_last_tx)) begin
          w_state_nxt = ST_RX_STROBE; w_rdn_nxt = 1'b0;
          w_cnt_nxt = CW'(RD_STROBE - 1); w_last_tx_nxt = 1'b0;
        end else if (w_tx_req) begin
          w_state_nxt = ST_TX_SETUP; w_oen_nxt = 1'b0; w_dout_nxt = r_tx_mem[r_tx_rd];
          w_cnt_nxt = CW'(WR_SETUP - 1); w_last_tx_nxt = 1'b1;
        end else if (SIWU_TIMEOUT > 0 && r_dirty && r_tx_level == '0) begin
          if (r_idle == IW'(SIWU_TIMEOUT - 1)) begin
            w_state_nxt = ST_SIWU; w_siwua_nxt = 1'b0; w_cnt_nxt = CW'(1);
          end else begin
            w_idle_nxt = r_idle + IW'(1);
          end
        end
      end
      ST_RX_STROBE: if (r_cnt == '0) begin
        w_rx_push = 1'b1; w_rdn_nxt = 1'b1;
        w_state_nxt = ST_RECOVER; w_cnt_nxt = CW'(RECOVER - 1);
      end
      ST_TX_SETUP: if (r_cnt == '0) begin
        w_wrn_nxt = 1'b0; w_state_nxt = ST_TX_STROBE; w_cnt_nxt = CW'(WR_STROBE - 1);
      end
      ST_TX_STROBE: if (r_cnt == '0) begin
        // OE#/data stay driven through recovery for hold time
        w_wrn_nxt = 1'b1; w_tx_pop = 1'b1; w_dirty_nxt = (SIWU_TIMEOUT > 0);
        w_state_nxt = ST_RECOVER; w_cnt_nxt = CW'(RECOVER - 1);
      end
      ST_RECOVER: if (r_cnt == '0) begin
        w_oen_nxt = 1'b1; w_state_nxt = ST_IDLE;
      end
      ST_SIWU: if (r_cnt == '0) begin
        w_siwua_nxt = 1'b1; w_dirty_nxt = 1'b0;
        w_state_nxt = ST_RECOVER; w_cnt_nxt = CW'(RECOVER - 1);
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state and registered pad outputs; reset releases strobes at once
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE; r_cnt <= '0; r_idle <= '0;
      r_rdn <= 1'b1; r_wrn <= 1'b1; r_oen <= 1'b1; r_siwua <= 1'b1;
      r_dout <= '0; r_last_tx <= 1'b1; r_dirty <= 1'b0;
    end else begin
      r_state <= w_state_nxt; r_cnt <= w_cnt_nxt; r_idle <= w_idle_nxt;
      r_rdn <= w_rdn_nxt; r_wrn <= w_wrn_nxt; r_oen <= w_oen_nxt; r_siwua <= w_siwua_nxt;
      r_dout <= w_dout_nxt; r_last_tx <= w_last_tx_nxt; r_dirty <= w_dirty_nxt;
    end
  end

  assign ftdi_rdn_o             = r_rdn;
  assign ftdi_wrn_o             = r_wrn;
  assign ftdi_oen_o             = r_oen;
  assign ftdi_siwua_o           = r_siwua;
  assign ftdi_data_out_o        = r_dout;
  assign bus_if.inport_accept_o = (r_tx_level != (TAW+1)'(TX_DEPTH));
  assign bus_if.outport_valid_o = (r_rx_level != '0);
  assign bus_if.outport_data_o  = r_rx_mem[r_rx_rd];
  assign rx_level_o             = r_rx_level;
  assign tx_level_o             = r_tx_level;

endmodule
